// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: state codes, opcode/funct constants, ALU codes and
// mux select encodings shared by the multicycle control unit.
package md_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF       = 5'd0,
        S_ID       = 5'd1,
        S_MEM_ADDR = 5'd2,
        S_MEM_RD   = 5'd3,
        S_MEM_WB   = 5'd4,
        S_MEM_WR   = 5'd5,
        S_R_EXE    = 5'd6,
        S_R_WB     = 5'd7,
        S_I_EXE    = 5'd8,
        S_I_WB     = 5'd9,
        S_LUI      = 5'd10,
        S_BRANCH   = 5'd11,
        S_JUMP     = 5'd12,
        S_JAL      = 5'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SRL = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_LUI = 2'd2;
    localparam logic [1:0] M2R_PC  = 2'd3;

    localparam logic [1:0] SB_RT  = 2'd0;
    localparam logic [1:0] SB_4   = 2'd1;
    localparam logic [1:0] SB_IMM = 2'd2;
    localparam logic [1:0] SB_BR  = 2'd3;

    localparam logic [1:0] PCS_ALU = 2'd0;
    localparam logic [1:0] PCS_OUT = 2'd1;
    localparam logic [1:0] PCS_JMP = 2'd2;

    // andi/ori/xori zero-extend; everything else with an imm sign-extends
    function automatic logic sign_ext(input logic [5:0] op);
        return op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI};
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// md_ctrl_if: control bundle between md_ctrl (master) and the
// multicycle datapath (slave).
interface md_ctrl_if;

    logic [31:0] Inst;
    logic        zero;
    logic        MIO_ready;
    logic        IorD;
    logic        IRWrite;
    logic        RegWrite;
    logic        ALUSrcA;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        Branch;
    logic        signsignal;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic [2:0]  ALU_operation;
    logic        MemRead;
    logic        MemWrite;
    logic        illegal_inst;
    logic [4:0]  state;

    modport master (
        input  Inst, zero, MIO_ready,
        output IorD, IRWrite, RegWrite, ALUSrcA, PCWrite,
        output PCWriteCond, Branch, signsignal,
        output RegDst, MemtoReg, ALUSrcB, PCSource,
        output ALU_operation, MemRead, MemWrite,
        output illegal_inst, state
    );

    modport slave (
        output Inst, zero, MIO_ready,
        input  IorD, IRWrite, RegWrite, ALUSrcA, PCWrite,
        input  PCWriteCond, Branch, signsignal,
        input  RegDst, MemtoReg, ALUSrcB, PCSource,
        input  ALU_operation, MemRead, MemWrite,
        input  illegal_inst, state
    );

endinterface

// File: rtl/md_alu_dec.sv
// md_alu_dec: op/funct to ALU operation, plus a flag saying whether
// the instruction is one this control unit supports.
module md_alu_dec
    import md_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        if (op == OP_R) begin
            case (funct)
                F_ADD:   alu_op = ALU_ADD;
                F_SUB:   alu_op = ALU_SUB;
                F_AND:   alu_op = ALU_AND;
                F_OR:    alu_op = ALU_OR;
                F_XOR:   alu_op = ALU_XOR;
                F_NOR:   alu_op = ALU_NOR;
                F_SLT:   alu_op = ALU_SLT;
                F_SRL:   alu_op = ALU_SRL;
                default: legal  = 1'b0;
            endcase
        end else begin
            case (op)
                OP_ADDI: alu_op = ALU_ADD;
                OP_ANDI: alu_op = ALU_AND;
                OP_ORI:  alu_op = ALU_OR;
                OP_XORI: alu_op = ALU_XOR;
                OP_SLTI: alu_op = ALU_SLT;
                OP_LW, OP_SW, OP_BEQ, OP_BNE,
                OP_J, OP_JAL, OP_LUI: alu_op = ALU_ADD;
                default: legal  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: Moore FSM sequencing the multicycle MIPS-subset datapath
// through fetch, decode, execute, memory and writeback.
module md_ctrl
    import md_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    md_ctrl_if.master bus
);

    state_t     st;
    state_t     nxt;
    logic [5:0] op;
    logic [5:0] funct;
    logic [2:0] dec_op;
    logic       legal;
    logic       unused_bits;

    assign op    = bus.Inst[31:26];
    assign funct = bus.Inst[5:0];

    // branch resolution happens in the datapath via PCWriteCond/Branch
    assign unused_bits = ^{bus.Inst[25:6], bus.zero};

    md_alu_dec u_dec (
        .op     (op),
        .funct  (funct),
        .alu_op (dec_op),
        .legal  (legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= S_IF;
        else        st <= nxt;
    end

    assign bus.state      = st;
    assign bus.signsignal = sign_ext(op);

    always_comb begin
        nxt               = st;
        bus.IorD          = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ALUSrcA       = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.PCWriteCond   = 1'b0;
        bus.Branch        = 1'b0;
        bus.RegDst        = RD_RT;
        bus.MemtoReg      = M2R_ALU;
        bus.ALUSrcB       = SB_RT;
        bus.PCSource      = PCS_ALU;
        bus.ALU_operation = ALU_AND;
        bus.MemRead       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.illegal_inst  = 1'b0;
        case (st)
            S_IF: begin
                bus.MemRead       = 1'b1;
                bus.IRWrite       = 1'b1;
                bus.ALUSrcB       = SB_4;
                bus.ALU_operation = ALU_ADD;
                bus.PCWrite       = 1'b1;
                if (bus.MIO_ready) nxt = S_ID;
            end
            S_ID: begin
                bus.ALUSrcB       = SB_BR;
                bus.ALU_operation = ALU_ADD;
                if (!legal) begin
                    bus.illegal_inst = 1'b1;
                    nxt              = S_IF;
                end else begin
                    case (op)
                        OP_LW, OP_SW:   nxt = S_MEM_ADDR;
                        OP_R:           nxt = S_R_EXE;
                        OP_BEQ, OP_BNE: nxt = S_BRANCH;
                        OP_J:           nxt = S_JUMP;
                        OP_JAL:         nxt = S_JAL;
                        OP_LUI:         nxt = S_LUI;
                        default:        nxt = S_I_EXE;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALUSrcB       = SB_IMM;
                bus.ALU_operation = ALU_ADD;
                nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                if (bus.MIO_ready) nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                bus.MemtoReg = M2R_MDR;
                bus.RegWrite = 1'b1;
                nxt          = S_IF;
            end
            S_MEM_WR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                if (bus.MIO_ready) nxt = S_IF;
            end
            S_R_EXE, S_I_EXE: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALUSrcB       = (st == S_R_EXE) ? SB_RT : SB_IMM;
                bus.ALU_operation = dec_op;
                nxt = (st == S_R_EXE) ? S_R_WB : S_I_WB;
            end
            S_R_WB: begin
                bus.RegDst   = RD_RD;
                bus.RegWrite = 1'b1;
                nxt          = S_IF;
            end
            S_I_WB: begin
                bus.RegWrite = 1'b1;
                nxt          = S_IF;
            end
            S_LUI: begin
                bus.MemtoReg = M2R_LUI;
                bus.RegWrite = 1'b1;
                nxt          = S_IF;
            end
            S_BRANCH: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALU_operation = ALU_SUB;
                bus.PCWriteCond   = 1'b1;
                bus.PCSource      = PCS_OUT;
                bus.Branch        = (op == OP_BEQ);
                nxt               = S_IF;
            end
            S_JUMP: begin
                bus.PCSource = PCS_JMP;
                bus.PCWrite  = 1'b1;
                nxt          = S_IF;
            end
            S_JAL: begin
                // PC already advanced in IF, so $31 gets PC+4 directly
                bus.PCSource = PCS_JMP;
                bus.PCWrite  = 1'b1;
                bus.RegDst   = RD_RA;
                bus.MemtoReg = M2R_PC;
                bus.RegWrite = 1'b1;
                nxt          = S_IF;
            end
            default: nxt = S_IF;
        endcase
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and randomized instruction streams checked
// cycle by cycle against an instruction-level reference model.
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    md_ctrl_if bus();

    md_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] st;
        logic       iord, irw, rw, asa, pcw, pcwc, br;
        logic [1:0] rdst, m2r, asb, pcs;
        logic [2:0] alu;
        logic       mr, mw, ill;
    } ctl_t;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_J = 4;
    localparam int K_JAL = 5, K_IALU = 6, K_LUI = 7, K_ILL = 8;

    ctl_t exp_q[$];
    bit   rdy_q[$];

    function automatic ctl_t observe();
        ctl_t c;
        c.st   = bus.state;
        c.iord = bus.IorD;
        c.irw  = bus.IRWrite;
        c.rw   = bus.RegWrite;
        c.asa  = bus.ALUSrcA;
        c.pcw  = bus.PCWrite;
        c.pcwc = bus.PCWriteCond;
        c.br   = bus.Branch;
        c.rdst = bus.RegDst;
        c.m2r  = bus.MemtoReg;
        c.asb  = bus.ALUSrcB;
        c.pcs  = bus.PCSource;
        c.alu  = bus.ALU_operation;
        c.mr   = bus.MemRead;
        c.mw   = bus.MemWrite;
        c.ill  = bus.illegal_inst;
        return c;
    endfunction

    function automatic bit funct_ok(logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                         6'b100110, 6'b100111, 6'b101010, 6'b000010};
    endfunction

    function automatic int kind(logic [31:0] w);
        case (w[31:26])
            6'b000000: return funct_ok(w[5:0]) ? K_R : K_ILL;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100, 6'b000101: return K_BR;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b001000, 6'b001100, 6'b001101,
            6'b001110, 6'b001010: return K_IALU;
            6'b001111: return K_LUI;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] ref_alu(logic [31:0] w);
        if (w[31:26] == 6'b000000) begin
            case (w[5:0])
                6'b100000: return 3'b010;
                6'b100010: return 3'b110;
                6'b100100: return 3'b000;
                6'b100101: return 3'b001;
                6'b100110: return 3'b011;
                6'b100111: return 3'b100;
                6'b101010: return 3'b111;
                default:   return 3'b101;
            endcase
        end
        case (w[31:26])
            6'b001100: return 3'b000;
            6'b001101: return 3'b001;
            6'b001110: return 3'b011;
            6'b001010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic ref_sign(logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000100,
                          6'b000101, 6'b001000, 6'b001010};
    endfunction

    function automatic ctl_t at(state_t s);
        ctl_t c = '0;
        c.st = s;
        return c;
    endfunction

    function automatic void push(ctl_t c, bit r);
        exp_q.push_back(c);
        rdy_q.push_back(r);
    endfunction

    // expected cycle-by-cycle control for one instruction
    task automatic build(logic [31:0] w, int nif, int nmem);
        ctl_t c;
        int   k = kind(w);
        exp_q.delete();
        rdy_q.delete();
        c = at(S_IF);
        c.mr = 1; c.irw = 1; c.asb = 2'd1; c.alu = 3'b010; c.pcw = 1;
        repeat (nif) push(c, 1'b0);
        push(c, 1'b1);
        c = at(S_ID);
        c.asb = 2'd3; c.alu = 3'b010; c.ill = (k == K_ILL);
        push(c, 1'($urandom));
        if (k == K_LW || k == K_SW) begin
            c = at(S_MEM_ADDR);
            c.asa = 1; c.asb = 2'd2; c.alu = 3'b010;
            push(c, 1'($urandom));
            c = at(k == K_LW ? S_MEM_RD : S_MEM_WR);
            c.iord = 1; c.mr = (k == K_LW); c.mw = (k == K_SW);
            repeat (nmem) push(c, 1'b0);
            push(c, 1'b1);
            if (k == K_LW) begin
                c = at(S_MEM_WB);
                c.m2r = 2'd1; c.rw = 1;
                push(c, 1'($urandom));
            end
        end
        case (k)
            K_R, K_IALU: begin
                c = at(k == K_R ? S_R_EXE : S_I_EXE);
                c.asa = 1; c.asb = (k == K_R) ? 2'd0 : 2'd2;
                c.alu = ref_alu(w);
                push(c, 1'($urandom));
                c = at(k == K_R ? S_R_WB : S_I_WB);
                c.rdst = (k == K_R) ? 2'd1 : 2'd0; c.rw = 1;
                push(c, 1'($urandom));
            end
            K_LUI: begin
                c = at(S_LUI);
                c.m2r = 2'd2; c.rw = 1;
                push(c, 1'($urandom));
            end
            K_BR: begin
                c = at(S_BRANCH);
                c.asa = 1; c.alu = 3'b110; c.pcwc = 1; c.pcs = 2'd1;
                c.br = (w[31:26] == 6'b000100);
                push(c, 1'($urandom));
            end
            K_J, K_JAL: begin
                c = at(k == K_J ? S_JUMP : S_JAL);
                c.pcs = 2'd2; c.pcw = 1;
                if (k == K_JAL) begin
                    c.rdst = 2'd2; c.m2r = 2'd3; c.rw = 1;
                end
                push(c, 1'($urandom));
            end
            default: ;
        endcase
    endtask

    task automatic run_inst(string name, logic [31:0] w,
                            int nif, int nmem, logic z);
        ctl_t got;
        build(w, nif, nmem);
        bus.Inst = w;
        foreach (exp_q[i]) begin
            bus.MIO_ready = rdy_q[i];
            bus.zero      = z;
            #1;
            got = observe();
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cyc%0d: got st=%0d ctl=%h want st=%0d ctl=%h",
                         name, i, got.st, got, exp_q[i].st, exp_q[i]);
            end
            if (exp_q[i].st != S_IF) begin
                checks++;
                if (bus.signsignal !== ref_sign(w[31:26])) begin
                    errors++;
                    $display("FAIL %s signsignal cyc%0d: got %b want %b",
                             name, i, bus.signsignal, ref_sign(w[31:26]));
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        ctl_t want = at(S_IF);
        ctl_t got;
        want.mr = 1; want.irw = 1; want.asb = 2'd1;
        want.alu = 3'b010; want.pcw = 1;
        #1;
        got = observe();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", got, want);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_memrd();
        int n = 0;
        bus.Inst = 32'h8C22_0004;
        bus.MIO_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.MIO_ready = 1'b0;
        #1;
        checks++;
        if (bus.state !== S_MEM_RD) begin
            errors++;
            $display("FAIL pre_reset_state: got %0d want %0d", bus.state, S_MEM_RD);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.state !== S_IF || bus.MemRead !== 1'b1 ||
            bus.RegWrite !== 1'b0 || bus.IorD !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got st=%0d mr=%b rw=%b iord=%b want st=0 mr=1 rw=0 iord=0",
                     bus.state, bus.MemRead, bus.RegWrite, bus.IorD);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.MIO_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.state !== S_ID) begin
            errors++;
            $display("FAIL post_reset_fetch: got %0d want %0d", bus.state, S_ID);
        end
        while (bus.state !== S_IF && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.state !== S_IF) begin
            errors++;
            $display("FAIL post_reset_drain: got %0d want %0d", bus.state, S_IF);
        end
    endtask

    task automatic test_cycle_counts();
        logic [31:0] insts[10] = '{32'h0022_1820, 32'h8C22_0004,
            32'hAC22_0004, 32'h2022_0005, 32'h3C01_1234, 32'h1022_0003,
            32'h1422_0003, 32'h0800_0010, 32'h0C00_0010, 32'hFC00_0000};
        int want[10] = '{4, 5, 4, 4, 3, 3, 3, 3, 3, 2};
        for (int i = 0; i < 10; i++) begin
            int n = 0;
            bus.Inst = insts[i];
            bus.MIO_ready = 1'b1;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (bus.state !== S_IF && n < 20);
            checks++;
            if (n != want[i]) begin
                errors++;
                $display("FAIL cycles_%h: got %0d want %0d", insts[i], n, want[i]);
            end
        end
    endtask

    task automatic test_directed();
        run_inst("add", 32'h0022_1820, 0, 0, 1'b0);
        run_inst("lw_stall", 32'h8C22_0004, 0, 2, 1'b0);
        run_inst("sw_stall", 32'hAC22_0008, 1, 1, 1'b0);
        run_inst("beq", 32'h1022_0003, 0, 0, 1'b1);
        run_inst("bne", 32'h1422_0003, 0, 0, 1'b1);
        run_inst("jal", 32'h0C00_0010, 0, 0, 1'b0);
        run_inst("illegal_op", 32'hFC00_0000, 0, 0, 1'b0);
        run_inst("illegal_fn", 32'h0022_1800, 2, 0, 1'b0);
        run_inst("lui", 32'h3C01_ABCD, 0, 0, 1'b0);
        run_inst("andi", 32'h3022_00FF, 0, 0, 1'b0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops[12] = '{6'b100011, 6'b101011, 6'b000100,
            6'b000101, 6'b000010, 6'b000011, 6'b001000, 6'b001100,
            6'b001101, 6'b001110, 6'b001010, 6'b001111};
        logic [5:0] fns[8] = '{6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b000010};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 15);
        if (k < 6) begin
            w[31:26] = 6'b000000;
            if (k == 5) begin
                do w[5:0] = 6'($urandom); while (funct_ok(w[5:0]));
            end else begin
                w[5:0] = fns[$urandom_range(0, 7)];
            end
        end else if (k < 15) begin
            w[31:26] = ops[$urandom_range(0, 11)];
        end else begin
            do w[31:26] = 6'($urandom);
            while (w[31:26] == 6'b0 || w[31:26] inside {ops});
        end
        return w;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            int nif  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            int nmem = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            run_inst("rand", rand_inst(), nif, nmem, 1'($urandom));
        end
    endtask

    initial begin
        bus.Inst      = 32'h0;
        bus.zero      = 1'b0;
        bus.MIO_ready = 1'b1;
        test_reset();
        test_directed();
        test_reset_mid_memrd();
        test_cycle_counts();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multicycle control unit for the MIPS-subset CPU: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It sits directly upstream of the multicycle datapath and drives every datapath control input from the IR contents and the ALU zero flag. It also generates the memory read/write strobes.

## Interface
Parameters:
- none (all encodings come from md_ctrl_pkg)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; low forces state IF immediately
- Inst  in  32  IR output of the datapath; only [31:26] op and [5:0] funct are used
- zero  in  1  ALU zero flag, combinational from the datapath
- MIO_ready  in  1  memory/IO ready; low stalls IF, MEM_RD and MEM_WR
- IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, signsignal  out  1 each  datapath controls
- RegDst, MemtoReg, ALUSrcB, PCSource  out  2 each  datapath mux selects
- ALU_operation  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt
- MemRead, MemWrite  out  1 each  memory strobes
- illegal_inst  out  1  high for the single ID cycle that decodes an unsupported op/funct
- state  out  5  current state code, for debug

## Operation
- Supported instructions: R-type add/sub/and/or/xor/nor/slt/srl; lw, sw, beq, bne, j, jal, addi, andi, ori, xori, slti, lui.
- Mux encodings:
  - RegDst: 0 rt, 1 rd, 2 $31.
  - MemtoReg: 0 ALUOut, 1 MDR, 2 {imm,16'h0}, 3 PC.
  - ALUSrcA: 0 PC, 1 rs.
  - ALUSrcB: 0 rt, 1 const 4, 2 imm, 3 imm<<2.
  - PCSource: 0 ALU res, 1 ALUOut, 2 jump target.
  - IorD: 0 PC, 1 ALUOut.
- Any output not listed for a state is 0.
- States and the outputs each one asserts:
  - IF: MemRead, IRWrite, ALUSrcB=1, add, PCWrite. Goes to ID when MIO_ready=1, else stays in IF.
  - ID: ALUSrcB=3, add, so ALUOut receives the branch target. Dispatches on op.
    - lw/sw -> MEM_ADDR; R-type -> R_EXE; beq/bne -> BRANCH; j -> JUMP; jal -> JAL.
    - addi/andi/ori/xori/slti -> I_EXE; lui -> LUI.
    - Any other op/funct -> IF, with illegal_inst=1.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, add. Goes to MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: IorD=1, MemRead. Goes to MEM_WB when MIO_ready=1, else stays.
  - MEM_WB: RegDst=0, MemtoReg=1, RegWrite. Goes to IF.
  - MEM_WR: IorD=1, MemWrite. Goes to IF when MIO_ready=1, else stays.
  - R_EXE: ALUSrcA=1, ALUSrcB=0, ALU_operation from the funct decode. Goes to R_WB.
  - R_WB: RegDst=1, MemtoReg=0, RegWrite. Goes to IF.
  - I_EXE: ALUSrcA=1, ALUSrcB=2, ALU op from the opcode (addi add, andi and, ori or, xori xor, slti slt). Goes to I_WB.
  - I_WB: RegDst=0, MemtoReg=0, RegWrite. Goes to IF.
  - LUI: RegDst=0, MemtoReg=2, RegWrite. Goes to IF.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, sub, PCWriteCond, PCSource=1. Branch=1 for beq, 0 for bne. Goes to IF.
  - JUMP: PCSource=2, PCWrite. Goes to IF.
  - JAL: PCSource=2, PCWrite, RegDst=2, MemtoReg=3, RegWrite. $31 receives the current PC, which is already PC+4. Goes to IF.
- signsignal: 1 for lw, sw, beq, bne, addi, slti; 0 otherwise (zero-extends andi/ori/xori). It is a combinational function of op and is valid in every state from ID onward.
- R-type funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl. Any other funct is illegal.

## Timing
- A single state register is clocked on the rising edge of clk. All outputs are combinational from the state register and Inst; there is no output register.
- Reset: while reset=0, state=IF and every output takes its IF value. The datapath PC is held by its own reset. The first fetch happens on the first edge after reset releases.
- Cycle counts with MIO_ready held at 1:
  - lw: 5 cycles.
  - sw, R-type, I-type ALU: 4 cycles.
  - lui, beq, bne, j, jal: 3 cycles.
  - Illegal instruction: 2 cycles.
- Each cycle with MIO_ready=0 in IF, MEM_RD or MEM_WR adds one cycle. Outputs stay stable during a stall.
- Reset asserted mid-instruction aborts it immediately. No partial writeback occurs after reset asserts.
- Inst is read only in ID and later states. It is stable there because IRWrite=1 only in IF.

## Structure
- md_ctrl_pkg holds:
  - state localparams (5-bit, binary);
  - opcode and funct constants;
  - ALU_operation codes;
  - mux select constants for RegDst, MemtoReg, ALUSrcB and PCSource.
- One sub-module, md_alu_dec: maps funct and op to ALU_operation and a legal flag. It is purely combinational and is reused by both R_EXE and I_EXE.

## Test plan
- Reset mid-MEM_RD: reset=0 -> state=IF and MemRead=1 asynchronously; after release, the next edge goes to ID.
- add $3,$1,$2 (0x00221820), MIO_ready=1 -> IF, ID, R_EXE, R_WB, IF. R_EXE has ALU_operation=010; R_WB has RegDst=1, RegWrite=1.
- lw (op 100011) with MIO_ready=0 for 2 cycles in MEM_RD -> 7 cycles total. MEM_WB has MemtoReg=1; signsignal=1 throughout.
- beq with zero=1, then bne with zero=1 -> both take 3 cycles with PCWriteCond=1 and PCSource=1; Branch=1 for beq and Branch=0 for bne.
- jal (0x0C000010) -> JAL state with RegDst=2, MemtoReg=3, PCSource=2, PCWrite=1, RegWrite=1.
- Op 111111 -> illegal_inst=1 for exactly one cycle, then IF; no RegWrite, MemWrite or PCWriteCond is asserted.
